// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
package div_pkg;

    localparam int unsigned DIVIDEND_W_DEF = 16;
    localparam int unsigned DIVISOR_W_DEF  = 8;
    localparam int unsigned CNT_W_DEF      = $clog2(DIVIDEND_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_cell_4.sv
// Single restoring-division step: shift in one dividend bit, then compare-subtract.
module div_cell_4 #(
    parameter int unsigned DIVISOR_W = 8
) (
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;

    // The shifted value needs one extra bit; after the conditional subtract it fits again.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? DIVISOR_W'(diff) : DIVISOR_W'(shifted);
    end

endmodule

// File: rtl/div_top_4.sv
// Iterative restoring divider, one quotient bit per clock.
// Optional macro DIV_ROUND_EN adds a ROUND state that rounds the quotient half-up.
module div_top_4
    import div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  result_rdy
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    div_state_t state_q, state_d;

    // Dividend register doubles as the quotient register: bits leave at the MSB, quotient enters at the LSB.
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    // Partial remainder after each step is always below the divisor, so DIVISOR_W bits suffice here.
    logic [DIVISOR_W-1:0]  rem_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DIVISOR_W-1:0]  rem_nxt;
    logic                  q_bit;
    logic [DIVIDEND_W-1:0] quo_nxt;
    logic                  last_iter;
    logic                  dz;

    logic                  accept;
    logic                  iterate;
    logic                  load_out;
    logic [DIVIDEND_W-1:0] out_quo_d;
    logic [DIVISOR_W-1:0]  out_rem_d;

    div_cell_4 #(
        .DIVISOR_W (DIVISOR_W)
    ) u_cell (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign quo_nxt   = {dvd_q[DIVIDEND_W-2:0], q_bit};
    assign last_iter = (cnt_q == CNT_W'(DIVIDEND_W - 1));
    assign dz        = (dvs_q == '0);

`ifdef DIV_ROUND_EN
    logic                  round_up;
    logic [DIVIDEND_W-1:0] quo_rnd;

    // Half-up rounding with saturation at all ones.
    always_comb begin
        round_up = ({rem_q, 1'b0} >= {1'b0, dvs_q});
        quo_rnd  = (round_up && (dvd_q != '1)) ? (dvd_q + DIVIDEND_W'(1)) : dvd_q;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        iterate   = 1'b0;
        load_out  = 1'b0;
        out_quo_d = '0;
        out_rem_d = '0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                iterate = 1'b1;
                if (last_iter) begin
`ifdef DIV_ROUND_EN
                    state_d = ROUND;
`else
                    state_d   = DONE;
                    load_out  = 1'b1;
                    out_quo_d = dz ? '1 : quo_nxt;
                    out_rem_d = dz ? '0 : rem_nxt;
`endif
                end
            end
            ROUND: begin
`ifdef DIV_ROUND_EN
                state_d   = DONE;
                load_out  = 1'b1;
                out_quo_d = dz ? '1 : quo_rnd;
                out_rem_d = dz ? '0 : rem_q;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand, iteration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            result_rdy  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (accept) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt_q <= '0;
            end
            if (iterate) begin
                dvd_q <= quo_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_out) begin
                quotient    <= out_quo_d;
                remainder   <= out_rem_d;
                div_by_zero <= dz;
            end
            result_rdy <= (state_d == DONE);
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_div_top_4.sv
// Scoreboard bench for div_top_4; expected results come from plain integer division.
module tb_div_top_4;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 8;
`ifdef DIV_ROUND_EN
    localparam int unsigned LAT = 18;
`else
    localparam int unsigned LAT = 17;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          busy;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;
    logic          result_rdy;

    div_top_4 #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .result_rdy  (result_rdy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] dz;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned acc);
        exp_t e;
        e.acc = acc;
        if (b == 0) begin
            e.q  = 32'hFFFF;
            e.r  = 0;
            e.dz = 1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 0;
`ifdef DIV_ROUND_EN
            if (2 * e.r >= b && e.q != 32'hFFFF) e.q = e.q + 1;
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && result_rdy) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy: got result_rdy=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), e.q);
                check("remainder", 32'(remainder), e.r);
                check("div_by_zero", 32'(div_by_zero), e.dz);
                check("latency", cyc - e.acc, LAT);
            end
        end
    end

    // Issue one division and follow it to completion; optionally pulse en while busy.
    task automatic run_op(input int unsigned a, input int unsigned b, input bit pulse_en);
        int unsigned n;
        bit          seen;
        bit          busy_bad;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        en       = 1'b1;
        dividend = DW'(a);
        divisor  = SW'(b);
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        en       = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
        n        = 1;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (n <= LAT + 3) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (result_rdy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            en = (pulse_en && (n == 5 || n == 10)) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        check("rdy_seen", 32'(seen), 1);
        check("rdy_cycle", n, LAT);
        check("busy_during", 32'(busy_bad), 0);
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        en       = 1'b1;
        dividend = DW'(1000);
        divisor  = SW'(7);
        @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dz", 32'(div_by_zero), 0);
        check("rst_rdy", 32'(result_rdy), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("init_quotient", 32'(quotient), 0);
        check("init_remainder", 32'(remainder), 0);
        check("init_dz", 32'(div_by_zero), 0);
        check("init_rdy", 32'(result_rdy), 0);
        check("init_busy", 32'(busy), 0);
        rst = 1'b0;

        run_op(1000, 7, 1'b0);
        run_op(32'hFFFF, 1, 1'b0);
        run_op(0, 255, 1'b0);
        run_op(500, 0, 1'b0);
        run_op(10, 3, 1'b0);
        run_op(1000, 7, 1'b1);
        run_op(10, 4, 1'b0);
        run_op(32'hFFFF, 2, 1'b0);
        reset_mid_op();
        run_op(200, 9, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int unsigned a;
            int unsigned b;
            int unsigned sel;
            a   = $urandom_range(0, 65535);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 0;
                1:       b = 1;
                2:       b = 255;
                default: b = $urandom_range(1, 255);
            endcase
            if (sel == 3) a = 65535;
            run_op(a, b, sel == 4);
        end

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
